// File: rtl/exp_bit_streamer.sv
// Ping-pong exponent buffer: loads REGISTER_SIZE-bit blocks into one bank while
// the other bank is served to the accumulator one bit per consume pulse, LSB first.
module exp_bit_streamer #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned BITS_IN_EXP   = 2048
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_in,
    input  logic [REGISTER_SIZE-1:0] block_in,
    output logic                     ready_out,
    output logic                     n_bit_out,
    output logic                     n_bit_valid_out,
    input  logic                     consumed_in,
    output logic                     last_bit_out,
    output logic                     done_out
);

    localparam int unsigned WORDS  = BITS_IN_EXP / REGISTER_SIZE;
    localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BIT_W  = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(REGISTER_SIZE - 1);

    logic [REGISTER_SIZE-1:0] mem_q [2][WORDS];

    logic [1:0]        full_q,    full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [WORD_W-1:0] wr_word_q, wr_word_d;
    logic              rd_bank_q, rd_bank_d;
    logic [WORD_W-1:0] rd_word_q, rd_word_d;
    logic [BIT_W-1:0]  rd_bit_q,  rd_bit_d;
    logic              done_q,    done_d;

    logic                     wr_acc_c;
    logic                     wr_fill_c;
    logic                     rd_acc_c;
    logic                     rd_last_c;
    logic                     rd_release_c;
    logic                     rd_valid_c;
    logic [REGISTER_SIZE-1:0] rd_data_c;

    assign rd_valid_c   = full_q[rd_bank_q];
    assign rd_last_c    = (rd_word_q == LAST_WORD) && (rd_bit_q == LAST_BIT);
    assign wr_acc_c     = valid_in && !full_q[wr_bank_q];
    assign wr_fill_c    = wr_acc_c && (wr_word_q == LAST_WORD);
    assign rd_acc_c     = consumed_in && rd_valid_c;
    assign rd_release_c = rd_acc_c && rd_last_c;
    assign rd_data_c    = mem_q[rd_bank_q][rd_word_q];

    assign ready_out       = !full_q[wr_bank_q];
    assign n_bit_valid_out = rd_valid_c;
    assign n_bit_out       = rd_valid_c && rd_data_c[rd_bit_q];
    assign last_bit_out    = rd_valid_c && rd_last_c;
    assign done_out        = done_q;

    // Next-state for both pointers; a release is applied before a fill so a set would win.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_word_d = wr_word_q;
        rd_bank_d = rd_bank_q;
        rd_word_d = rd_word_q;
        rd_bit_d  = rd_bit_q;
        done_d    = 1'b0;

        if (rd_acc_c) begin
            if (rd_bit_q == LAST_BIT) begin
                rd_bit_d = '0;
                if (rd_last_c) begin
                    rd_word_d         = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    done_d            = 1'b1;
                end else begin
                    rd_word_d = rd_word_q + WORD_W'(1);
                end
            end else begin
                rd_bit_d = rd_bit_q + BIT_W'(1);
            end
        end

        if (wr_acc_c) begin
            if (wr_fill_c) begin
                wr_word_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_word_d = wr_word_q + WORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_word_q <= '0;
            rd_bank_q <= 1'b0;
            rd_word_q <= '0;
            rd_bit_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_word_q <= wr_word_d;
            rd_bank_q <= rd_bank_d;
            rd_word_q <= rd_word_d;
            rd_bit_q  <= rd_bit_d;
            done_q    <= done_d;
        end
    end

    // Bank storage has no reset; contents are only observed while the bank is full.
    always_ff @(posedge clk_in) begin
        if (wr_acc_c) begin
            mem_q[wr_bank_q][wr_word_q] <= block_in;
        end
    end

    a_no_fill_release_collision : assert property (
        @(posedge clk_in) disable iff (rst_in)
        !(wr_fill_c && rd_release_c && (wr_bank_q == rd_bank_q))
    );

endmodule
